// File: rtl/deskew_addr_scan.sv
// Frame-scan read-address generator: walks width x height pixels, one address per handshake.
// Optional bound check on emitted addresses is built when DESKEW_ADDR_SCAN_BOUND_CHECK_EN is defined.
module deskew_addr_scan #(
  parameter int ADDR_W    = 17,
  parameter int COORD_W   = 9,
  parameter int MEM_DEPTH = 76800
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sclr,
  input  logic [ADDR_W-1:0]  offset,
  input  logic [COORD_W-1:0] stride,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic [COORD_W-1:0] shift,
  output logic [ADDR_W-1:0]  addr,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic               busy,
  output logic               done,
  output logic               oob_err
);

  // Handshake: a pixel transfers on any cycle with addr_valid && addr_ready; addr and
  // addr_valid depend only on registered state, so they hold steady while ready is low.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  offset_q;
  logic [ADDR_W-1:0]  row_acc;
  logic [COORD_W-1:0] stride_q;
  logic [COORD_W-1:0] width_q;
  logic [COORD_W-1:0] height_q;
  logic [COORD_W-1:0] shift_q;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               done_q;

  logic xfer;
  logic last_col;
  logic last_row;
  logic size_ok;
  logic start_ok;

  assign xfer     = (state == RUN) && addr_ready && !sclr;
  assign last_col = (x == width_q - COORD_W'(1));
  assign last_row = (y == height_q - COORD_W'(1));
  assign size_ok  = (width != '0) && (height != '0);
  assign start_ok = (state == IDLE) && start && size_ok && !sclr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (sclr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && size_ok) state_next = RUN;
        RUN:     if (addr_ready && last_col && last_row) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_valid = (state == RUN);
    busy       = (state == RUN);
  end

  assign addr = offset_q + row_acc + ADDR_W'(shift_q) + ADDR_W'(x);
  assign done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      row_acc  <= '0;
      stride_q <= '0;
      width_q  <= '0;
      height_q <= '0;
      shift_q  <= '0;
      x        <= '0;
      y        <= '0;
      done_q   <= 1'b0;
    end else if (sclr) begin
      row_acc  <= '0;
      x        <= '0;
      y        <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && start) begin
        if (size_ok) begin
          offset_q <= offset;
          stride_q <= stride;
          width_q  <= width;
          height_q <= height;
          shift_q  <= shift;
          row_acc  <= '0;
          x        <= '0;
          y        <= '0;
        end else begin
          // Degenerate region: no addresses, but the controller still sees completion.
          done_q <= 1'b1;
        end
      end else if (xfer) begin
        if (!last_col) begin
          x <= x + COORD_W'(1);
        end else if (!last_row) begin
          x       <= '0;
          y       <= y + COORD_W'(1);
          row_acc <= row_acc + ADDR_W'(stride_q);
          shift_q <= shift;
        end else begin
          x       <= '0;
          y       <= '0;
          row_acc <= '0;
          done_q  <= 1'b1;
        end
      end
    end
  end

`ifdef DESKEW_ADDR_SCAN_BOUND_CHECK_EN
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  logic oob_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   oob_q <= 1'b0;
    else if (start_ok)                            oob_q <= 1'b0;
    else if (xfer && ({1'b0, addr} >= MEM_LIMIT)) oob_q <= 1'b1;
  end

  assign oob_err = oob_q;
`else
  // Constant zero; no comparator is built in this configuration.
  assign oob_err = (MEM_DEPTH < 0);
`endif

endmodule

// File: tb/tb_deskew_addr_scan.sv
// Directed bench for deskew_addr_scan: scans, shift, backpressure, wrap, abort, reset, bound check.
module tb_deskew_addr_scan;

  localparam int ADDR_W  = 17;
  localparam int COORD_W = 9;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               sclr;
  logic [ADDR_W-1:0]  offset;
  logic [COORD_W-1:0] stride;
  logic [COORD_W-1:0] width;
  logic [COORD_W-1:0] height;
  logic [COORD_W-1:0] shift;
  logic [ADDR_W-1:0]  addr;
  logic               addr_valid;
  logic               addr_ready;
  logic               busy;
  logic               done;
  logic               oob_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] got_q[$];

  deskew_addr_scan #(.ADDR_W(ADDR_W), .COORD_W(COORD_W), .MEM_DEPTH(76800)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sclr(sclr),
    .offset(offset), .stride(stride), .width(width), .height(height), .shift(shift),
    .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .busy(busy), .done(done), .oob_err(oob_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one scan from start to done; ready_mode 0 = always ready, 1 = pattern 1,0,0.
  // mid_start pulses start with different settings during the scan.
  task automatic run_scan(input string tag,
                          input logic [ADDR_W-1:0] off, input logic [COORD_W-1:0] str,
                          input logic [COORD_W-1:0] w, input logic [COORD_W-1:0] h,
                          input logic [COORD_W-1:0] sh0, input logic [COORD_W-1:0] sh1,
                          input int ready_mode, input bit mid_start,
                          output int oob_first);
    int done_cnt, done_i, last_xfer_i, vcnt;
    bit stalled;
    logic [ADDR_W-1:0] prev_addr;
    got_q.delete();
    done_cnt = 0; done_i = -1; last_xfer_i = 0; vcnt = 0;
    stalled = 1'b0; prev_addr = '0; oob_first = -1;
    @(negedge clk);
    start = 1'b1; offset = off; stride = str; width = w; height = h; shift = sh0;
    addr_ready = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      shift = sh1;
      if (i == 1) check({tag, " busy_after_start"}, busy, (w != 0 && h != 0));
      if (mid_start && i == 3) begin
        start = 1'b1; offset = '0; width = 9'd1; height = 9'd1; stride = '0;
      end
      if (oob_err && oob_first < 0) oob_first = got_q.size();
      if (done) begin
        done_cnt++;
        done_i = i;
        break;
      end
      if (addr_valid) begin
        if (stalled) check({tag, " stall_hold"}, addr, prev_addr);
        addr_ready = (ready_mode == 0) ? 1'b1 : ((vcnt % 3) == 0);
        vcnt++;
        if (addr_ready) begin
          got_q.push_back(addr);
          last_xfer_i = i;
        end
        stalled = !addr_ready;
        prev_addr = addr;
      end else begin
        addr_ready = 1'b0;
      end
    end
    check({tag, " done_seen"}, done_cnt, 1);
    check({tag, " done_timing"}, done_i, last_xfer_i + 1);
    check({tag, " xfer_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s addr[%0d]", tag, k), got_q[k], exp_q[k]);
    @(negedge clk);
    addr_ready = 1'b0;
    check({tag, " done_single"}, done, 1'b0);
    check({tag, " idle_valid"}, addr_valid, 1'b0);
    check({tag, " idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    int oob_first;
    rst_n = 1'b0; start = 1'b0; sclr = 1'b0; addr_ready = 1'b0;
    offset = '0; stride = '0; width = '0; height = '0; shift = '0;
    repeat (3) @(negedge clk);
    check("rst addr", addr, 0);
    check("rst addr_valid", addr_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst oob_err", oob_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q = '{100, 101, 102, 420, 421, 422};
    run_scan("basic", 17'd100, 9'd320, 9'd3, 9'd2, 9'd0, 9'd0, 0, 1'b0, oob_first);

    exp_q = '{105, 106, 107, 427, 428, 429};
    run_scan("shift", 17'd100, 9'd320, 9'd3, 9'd2, 9'd5, 9'd7, 0, 1'b0, oob_first);

    exp_q = '{100, 101, 102, 420, 421, 422};
    run_scan("bp", 17'd100, 9'd320, 9'd3, 9'd2, 9'd0, 9'd0, 1, 1'b1, oob_first);

    exp_q = '{131070, 131071, 0, 1};
    run_scan("wrap", 17'd131070, 9'd0, 9'd4, 9'd1, 9'd0, 9'd0, 0, 1'b0, oob_first);

    exp_q = '{};
    run_scan("h0", 17'd50, 9'd10, 9'd4, 9'd0, 9'd0, 9'd0, 0, 1'b0, oob_first);

    // abort after two transfers of a 3x2 scan
    @(negedge clk);
    start = 1'b1; offset = 17'd100; stride = 9'd320; width = 9'd3; height = 9'd2; shift = '0;
    @(negedge clk);
    start = 1'b0; addr_ready = 1'b1;
    check("abort a0", addr, 100);
    @(negedge clk);
    check("abort a1", addr, 101);
    @(negedge clk);
    check("abort a2", addr, 102);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0; addr_ready = 1'b0;
    check("abort valid", addr_valid, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    @(negedge clk);
    check("abort done_later", done, 0);
    exp_q = '{200, 201, 202, 520, 521, 522};
    run_scan("restart", 17'd200, 9'd320, 9'd3, 9'd2, 9'd0, 9'd0, 0, 1'b0, oob_first);

    // asynchronous reset in the middle of a scan
    @(negedge clk);
    start = 1'b1; offset = 17'd300; stride = 9'd1; width = 9'd3; height = 9'd3;
    @(negedge clk);
    start = 1'b0; addr_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async addr", addr, 0);
    check("async valid", addr_valid, 0);
    check("async busy", busy, 0);
    addr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("async still_idle", addr_valid, 0);

    exp_q = '{76798, 76799, 76800, 76801};
    run_scan("bound", 17'd76798, 9'd0, 9'd4, 9'd1, 9'd0, 9'd0, 0, 1'b0, oob_first);
`ifdef DESKEW_ADDR_SCAN_BOUND_CHECK_EN
    check("bound first", oob_first, 3);
    check("bound sticky", oob_err, 1);
`else
    check("bound first", oob_first, -1);
    check("bound sticky", oob_err, 0);
`endif
    exp_q = '{10, 11};
    run_scan("clear", 17'd10, 9'd0, 9'd2, 9'd1, 9'd0, 9'd0, 0, 1'b0, oob_first);
    check("clear oob", oob_err, 0);
    check("clear first", oob_first, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/deskew_addr_scan.md
Name: deskew_addr_scan

Overview:
- Parametrised frame-scan address generator for the deskew datapath.
- Successor to the single-accumulator line-address generator. Walks a rectangular region row by row and emits one read address per handshake.
- Address per pixel = base offset + row stride accumulation + per-row skew shift + column index.
- Sits between the deskew control FSM and the line/frame buffer read port.

Parameters:
- ADDR_W, 17, width of the memory address and of the offset/row accumulator.
- COORD_W, 9, width of the column/row counters, stride, shift and size inputs.
- MEM_DEPTH, 76800, number of valid memory words; used only by the optional bound check.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a scan; sampled only in IDLE.
- sclr  in  1  synchronous abort; returns to IDLE, clears all counters.
- offset  in  ADDR_W  base address, latched on accepted start.
- stride  in  COORD_W  row increment, latched on accepted start.
- width  in  COORD_W  pixels per row, latched on accepted start.
- height  in  COORD_W  rows per scan, latched on accepted start.
- shift  in  COORD_W  per-row skew, unsigned; sampled at start and at every row advance.
- addr  out  ADDR_W  current address.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  consumer accepts addr when addr_valid && addr_ready.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the scan ends.
- oob_err  out  1  sticky out-of-bounds flag (see Optional Feature).

Behaviour:
- Reset values: addr=0, addr_valid=0, busy=0, done=0, oob_err=0. All internal counters and the FSM state reset to 0/IDLE.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on start when width!=0 and height!=0.
  - On that transition: latch offset/stride/width/height, latch shift, set row_acc=0, x=0, y=0.
  - start with width==0 or height==0: stay in IDLE, pulse done the next cycle, emit no addresses.
- Address formula: addr = (offset + row_acc + shift_q + x) mod 2^ADDR_W. Truncate each sum to ADDR_W bits; wrap-around is silent.
- addr is a combinational function of registered state only, with no extra pipeline stage.
- Latency: addr_valid and busy rise the cycle after the accepted start. addr_valid=busy=1 throughout RUN.
- Handshake:
  - addr must stay stable while addr_valid && !addr_ready.
  - Each transfer advances exactly one pixel. No advance without a transfer.
- Advance on transfer:
  - If x < width-1: x increments.
  - Else: x=0, y increments, row_acc += stride (mod 2^ADDR_W), shift_q is re-sampled from shift.
  - Transfer on the last pixel (x==width-1, y==height-1): go to IDLE, pulse done the next cycle, drop addr_valid and busy.
- Exactly width*height transfers occur per scan.
- start while in RUN is ignored.
- sclr has priority over start and over transfers. It forces IDLE, addr_valid=0 and busy=0 on the next edge, does not pulse done, and does not clear oob_err.
- Async reset mid-scan aborts immediately, with all outputs at reset values.
- Width/height/stride/offset input changes during RUN have no effect; shift is sampled only at row boundaries.

Optional Feature:
- Macro: DESKEW_ADDR_SCAN_BOUND_CHECK_EN.
- Defined: on every transfer with addr >= MEM_DEPTH, oob_err sets. It stays set until reset or an accepted start. The address is still emitted unchanged.
- Undefined: oob_err is tied to 0 and the comparator is not built.

Test Plan:
- Basic scan: offset=100, stride=320, width=3, height=2, shift=0, ready=1 -> addr sequence 100,101,102,420,421,422. done pulses once, the cycle after the last transfer.
- Per-row shift: same setup, shift=5 at start and 7 at the row advance -> 105,106,107,427,428,429.
- Backpressure: addr_ready toggled 1,0,0,1,... -> addr holds stable on stall cycles, no pixel skipped or repeated, total transfers = width*height.
- Wrap and degenerate size: offset=2^17-2, width=4, height=1 -> 131070,131071,0,1. A separate start with height=0 -> no addr_valid, done pulse one cycle later.
- Abort: sclr after 2 transfers of a 3x2 scan -> IDLE next edge, no done. A new start restarts from offset.
- Bound check (macro defined, MEM_DEPTH=76800): offset=76798, width=4, height=1 -> oob_err set on the third transfer (addr 76800), remains set after the scan, cleared by the next start.
